// File: rtl/data_sram_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_axi_bridge_pkg
// Description : Shared types and constants for the data-SRAM to AXI4-Lite
//               bridge. It holds the bridge state encoding, the AXI OKAY
//               response code, the word transfer size code, and a helper
//               that classifies AXI responses.
// Revision    : 1.0 - initial release
// ============================================================================
package data_sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_AR   = 3'd1,
        ST_RD_R    = 3'd2,
        ST_WR_AW_W = 3'd3,
        ST_WR_B    = 3'd4,
        ST_DONE    = 3'd5
    } bridge_state_t;

    localparam logic [1:0] c_AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0] c_AXI_SIZE_WORD = 3'b010;

    // Any response other than OKAY (SLVERR, DECERR, EXOKAY) counts as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != c_AXI_RESP_OKAY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_axi_bridge
// Description : Turns the CPU data-SRAM port into a single-outstanding
//               AXI4-Lite-style master. The request is latched in IDLE and
//               replayed on AXI. data_sram_stall holds the MEM stage until
//               the one-cycle DONE state, where read data is valid.
// Ports       : clk, reset                 - clock, async active-high reset
//               data_sram_en/we/addr/wdata - CPU request (held while stalled)
//               data_sram_rdata/stall      - CPU read data and stall
//               ar*/r*                     - AXI read address/data channels
//               aw*/w*/b*                  - AXI write address/data/response
//               bus_err                    - sticky error (DATA_BRIDGE_ERR_EN)
// Options     : `define DATA_BRIDGE_ERR_EN adds the bus_err output
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_axi_bridge
    import data_sram_axi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_sram_en,
    input  logic [DATA_WIDTH/8-1:0] data_sram_we,
    input  logic [ADDR_WIDTH-1:0]   data_sram_addr,
    input  logic [DATA_WIDTH-1:0]   data_sram_wdata,
    output logic [DATA_WIDTH-1:0]   data_sram_rdata,
    output logic                    data_sram_stall,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
`ifdef DATA_BRIDGE_ERR_EN
    ,
    output logic                    bus_err
`endif
);

    bridge_state_t             r_state;
    bridge_state_t             w_state_next;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_we;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_aw_done;
    logic                      r_w_done;

    logic w_req;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_r_hs;
    logic w_b_hs;

    // All AXI valids/readys decode purely from registered state, so they
    // appear the cycle after the request and never follow inputs directly.
    assign arvalid = (r_state == ST_RD_AR);
    assign rready  = (r_state == ST_RD_R);
    assign awvalid = (r_state == ST_WR_AW_W) & ~r_aw_done;
    assign wvalid  = (r_state == ST_WR_AW_W) & ~r_w_done;
    assign bready  = (r_state == ST_WR_B);

    assign araddr  = r_addr;
    assign awaddr  = r_addr;
    assign wdata   = r_wdata;
    assign wstrb   = r_we;

    assign data_sram_rdata = r_rdata;
    // In DONE the CPU's still-asserted en is the completed request; releasing
    // stall lets MEM advance so it is never reissued.
    assign data_sram_stall = data_sram_en & (r_state != ST_DONE);

    assign w_req   = (r_state == ST_IDLE) & data_sram_en;
    assign w_aw_hs = awvalid & awready;
    assign w_w_hs  = wvalid & wready;
    assign w_r_hs  = rready & rvalid;
    assign w_b_hs  = bready & bvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (data_sram_en) begin
                    w_state_next = (data_sram_we == '0) ? ST_RD_AR : ST_WR_AW_W;
                end
            end
            ST_RD_AR: begin
                if (arready) begin
                    w_state_next = ST_RD_R;
                end
            end
            ST_RD_R: begin
                if (rvalid) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_WR_AW_W: begin
                // A handshake completing this cycle counts the same as one
                // already recorded in its flag.
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_state_next = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (bvalid) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= '0;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_req) begin
                r_addr    <= data_sram_addr;
                r_wdata   <= data_sram_wdata;
                r_we      <= data_sram_we;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                end
            end
            if (w_r_hs) begin
                r_rdata <= rdata;
            end
        end
    end

`ifdef DATA_BRIDGE_ERR_EN
    logic r_bus_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else if ((w_r_hs & resp_is_err(rresp)) | (w_b_hs & resp_is_err(bresp))) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    // Responses carry no meaning without the error output.
    logic w_unused_resp;
    assign w_unused_resp = ^{rresp, bresp};
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_axi_bridge
// Description : Scoreboard bench for data_sram_axi_bridge. A CPU driver issues
//               requests and pushes expected results from a byte-level memory
//               model; a reactive AXI slave with configurable or random
//               delays serves them; a monitor pops and compares on every AXI
//               handshake and on each DONE cycle.
// Options     : `define DATA_BRIDGE_ERR_EN also exercises bus_err
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_sram_axi_bridge;

    logic        clk;
    logic        reset;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_stall;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
`ifdef DATA_BRIDGE_ERR_EN
    logic        bus_err;
`endif

    data_sram_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .data_sram_stall(data_sram_stall),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef DATA_BRIDGE_ERR_EN
        , .bus_err(bus_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        wr;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [3:0]  we;
        bit [31:0] rdata;
    } txn_t;

    txn_t      exp_q[$];
    bit [31:0] ref_mem [bit [31:0]];
    bit [31:0] slv_mem [bit [31:0]];
    bit [31:0] last_rdata;

    int total;
    int bad;

    // slave delay configuration; negative selects a random 0..3 delay
    int       cfg_ar, cfg_r, cfg_aw, cfg_w, cfg_b;
    bit [1:0] cfg_rresp, cfg_bresp;

    // valid-high cycle counts of the most recently completed transaction
    int mon_ar, mon_aw, mon_w;
    int done_ar, done_aw, done_w;

    function automatic bit [31:0] init_word(input bit [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic int pick(input int c);
        return (c < 0) ? int'($urandom_range(0, 3)) : c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_now();
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "run aborted");
    endtask

    // ---------------------------------------------------------------- slave
    initial begin : slave
        bit ar_busy, r_pend, aw_busy, w_busy, aw_got, w_got, b_pend;
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        bit [31:0] r_a, aw_a, w_d, cur;
        bit [3:0]  w_s;
        ar_busy = 0; r_pend = 0; aw_busy = 0; w_busy = 0;
        aw_got = 0; w_got = 0; b_pend = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ar_busy = 0; r_pend = 0; aw_busy = 0; w_busy = 0;
                aw_got = 0; w_got = 0; b_pend = 0;
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                continue;
            end
            // R before AR so data never comes in the same cycle as its address
            rvalid = 0;
            rdata  = $urandom;
            rresp  = 2'($urandom_range(0, 3));
            if (r_pend) begin
                if (r_cnt == 0) begin
                    rvalid = 1;
                    rdata  = slv_mem.exists(r_a) ? slv_mem[r_a] : init_word(r_a);
                    rresp  = cfg_rresp;
                    if (rready) r_pend = 0;
                end else r_cnt--;
            end
            arready = 0;
            if (arvalid) begin
                if (!ar_busy) begin ar_busy = 1; ar_cnt = pick(cfg_ar); end
                if (ar_cnt == 0) begin
                    arready = 1; ar_busy = 0;
                    r_pend = 1; r_cnt = pick(cfg_r); r_a = araddr & ~32'h3;
                end else ar_cnt--;
            end
            bvalid = 0;
            bresp  = 2'($urandom_range(0, 3));
            if (b_pend) begin
                if (b_cnt == 0) begin
                    bvalid = 1; bresp = cfg_bresp;
                    if (bready) b_pend = 0;
                end else b_cnt--;
            end
            awready = 0;
            if (awvalid) begin
                if (!aw_busy) begin aw_busy = 1; aw_cnt = pick(cfg_aw); end
                if (aw_cnt == 0) begin
                    awready = 1; aw_busy = 0; aw_got = 1; aw_a = awaddr & ~32'h3;
                end else aw_cnt--;
            end
            wready = 0;
            if (wvalid) begin
                if (!w_busy) begin w_busy = 1; w_cnt = pick(cfg_w); end
                if (w_cnt == 0) begin
                    wready = 1; w_busy = 0; w_got = 1; w_d = wdata; w_s = wstrb;
                end else w_cnt--;
            end
            if (aw_got && w_got) begin
                cur = slv_mem.exists(aw_a) ? slv_mem[aw_a] : init_word(aw_a);
                for (int b = 0; b < 4; b++)
                    if (w_s[b]) cur[8*b +: 8] = w_d[8*b +: 8];
                slv_mem[aw_a] = cur;
                aw_got = 0; w_got = 0;
                b_pend = 1; b_cnt = pick(cfg_b);
            end
        end
    end

    // -------------------------------------------------------------- monitor
    initial begin : monitor
        bit ar_wait, aw_wait, w_wait, prev_stall;
        bit [31:0] p_araddr, p_awaddr, p_wdata, p_addr, p_wd;
        bit [3:0]  p_wstrb, p_we;
        bit        p_en;
        txn_t      t;
        ar_wait = 0; aw_wait = 0; w_wait = 0; prev_stall = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                ar_wait = 0; aw_wait = 0; w_wait = 0; prev_stall = 0;
                mon_ar = 0; mon_aw = 0; mon_w = 0;
                continue;
            end
            assert (!prev_stall || (data_sram_en === p_en && data_sram_addr === p_addr &&
                    data_sram_we === p_we && data_sram_wdata === p_wd))
                else $error("CPU request changed while stalled");
            if (ar_wait) begin
                check("arvalid_hold", arvalid, 1'b1);
                check("araddr_stable", araddr, p_araddr);
            end
            if (aw_wait) begin
                check("awvalid_hold", awvalid, 1'b1);
                check("awaddr_stable", awaddr, p_awaddr);
            end
            if (w_wait) begin
                check("wvalid_hold", wvalid, 1'b1);
                check("wdata_stable", wdata, p_wdata);
                check("wstrb_stable", wstrb, p_wstrb);
            end
            ar_wait = arvalid && !arready;
            aw_wait = awvalid && !awready;
            w_wait  = wvalid && !wready;
            p_araddr = araddr; p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb;
            prev_stall = data_sram_stall;
            p_en = data_sram_en; p_addr = data_sram_addr; p_we = data_sram_we; p_wd = data_sram_wdata;
            if (arvalid) mon_ar++;
            if (awvalid) mon_aw++;
            if (wvalid)  mon_w++;

            if (arvalid && arready) begin
                if (exp_q.size() == 0 || exp_q[0].wr) begin
                    total++; bad++;
                    $display("FAIL ar_unexpected: got read addr %h expected no read", araddr);
                end else check("araddr", araddr, exp_q[0].addr);
            end
            if (awvalid && awready) begin
                if (exp_q.size() == 0 || !exp_q[0].wr) begin
                    total++; bad++;
                    $display("FAIL aw_unexpected: got write addr %h expected no write", awaddr);
                end else check("awaddr", awaddr, exp_q[0].addr);
            end
            if (wvalid && wready) begin
                if (exp_q.size() == 0 || !exp_q[0].wr) begin
                    total++; bad++;
                    $display("FAIL w_unexpected: got wdata %h expected no write", wdata);
                end else begin
                    check("wdata", wdata, exp_q[0].wdata);
                    check("wstrb", wstrb, exp_q[0].we);
                end
            end
            if (data_sram_en && !data_sram_stall) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got DONE expected none");
                end else begin
                    t = exp_q.pop_front();
                    if (t.wr) check("rdata_kept_on_write", data_sram_rdata, last_rdata);
                    else begin
                        check("rdata", data_sram_rdata, t.rdata);
                        last_rdata = t.rdata;
                    end
                end
                done_ar = mon_ar; done_aw = mon_aw; done_w = mon_w;
                mon_ar = 0; mon_aw = 0; mon_w = 0;
            end
        end
    end

    // --------------------------------------------------------------- driver
    // Called just after a rising edge; returns once DONE has been seen and
    // the following edge has passed, with en low again.
    task automatic do_req(input bit wr, input bit [31:0] addr, input bit [31:0] wd,
                          input bit [3:0] we, output int stall_cycles);
        txn_t      t;
        bit [31:0] wa, cur;
        int        n;
        wa  = addr & ~32'h3;
        cur = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
        t.wr = wr; t.addr = addr; t.wdata = wd; t.we = wr ? we : 4'b0; t.rdata = cur;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (we[b]) cur[8*b +: 8] = wd[8*b +: 8];
            ref_mem[wa] = cur;
        end
        exp_q.push_back(t);
        data_sram_en    = 1'b1;
        data_sram_we    = wr ? we : 4'b0;
        data_sram_addr  = addr;
        data_sram_wdata = wd;
        stall_cycles    = 0;
        @(negedge clk);
        check("no_valid_in_req_cycle", {arvalid, awvalid, wvalid}, 3'b000);
        n = 0;
        while (data_sram_stall) begin
            stall_cycles++;
            n++;
            if (n > 500) begin
                total++; bad++;
                $display("FAIL req_timeout: got stall still high expected DONE within 500 cycles");
                finish_now();
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        data_sram_en    = 1'b0;
        data_sram_we    = 4'($urandom);
        data_sram_addr  = $urandom;
        data_sram_wdata = $urandom;
    endtask

    function automatic bit [31:0] rnd_addr();
        return 32'h1C00_0000 | {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        finish_now();
    end

    initial begin : stim
        int sc, n;
        total = 0; bad = 0; last_rdata = 0;
        cfg_ar = 0; cfg_r = 0; cfg_aw = 0; cfg_w = 0; cfg_b = 0;
        cfg_rresp = 2'b00; cfg_bresp = 2'b00;
        reset = 1'b1;
        data_sram_en = 0; data_sram_we = 0; data_sram_addr = 0; data_sram_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_rdata", data_sram_rdata, 32'h0);
        check("rst_stall", data_sram_stall, 1'b0);
`ifdef DATA_BRIDGE_ERR_EN
        check("rst_bus_err", bus_err, 1'b0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // zero-wait read
        ref_mem[32'h1C00_0100] = 32'hDEADBEEF;
        slv_mem[32'h1C00_0100] = 32'hDEADBEEF;
        do_req(0, 32'h1C00_0100, 32'h0, 4'h0, sc);
        check("zero_wait_read_stall", sc, 3);

        // read with address and data backpressure
        cfg_ar = 4; cfg_r = 2;
        do_req(0, 32'h1C00_0104, 32'h0, 4'h0, sc);
        check("bp_read_arvalid_cycles", done_ar, 5);

        // write: aw accepted at once, w after two waits, b after one wait
        cfg_ar = 0; cfg_r = 0; cfg_aw = 0; cfg_w = 2; cfg_b = 1;
        do_req(1, 32'h1C00_0200, 32'h12345678, 4'b0011, sc);
        check("aw_first_awvalid_cycles", done_aw, 1);
        check("aw_first_wvalid_cycles", done_w, 3);
        check("aw_first_write_stall", sc, 6);

        // simultaneous aw/w, then back-to-back read of the same word
        cfg_w = 0; cfg_b = 0;
        do_req(1, 32'h1C00_0200, 32'hA1B2C3D4, 4'b1100, sc);
        check("sim_write_stall", sc, 3);
        do_req(0, 32'h1C00_0200, 32'h0, 4'h0, sc);
        check("b2b_read_stall", sc, 3);

        // reset while waiting in RD_R
        cfg_r = 20;
        exp_q.push_back('{wr: 0, addr: 32'h1C00_0300, wdata: 0, we: 0, rdata: 0});
        data_sram_en = 1; data_sram_we = 0; data_sram_addr = 32'h1C00_0300; data_sram_wdata = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rready && n < 50);
        check("reached_rd_r", rready, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_arvalid", arvalid, 1'b0);
        check("async_rst_rready", rready, 1'b0);
        check("async_rst_awvalid", awvalid, 1'b0);
        check("async_rst_wvalid", wvalid, 1'b0);
        check("async_rst_bready", bready, 1'b0);
        check("async_rst_rdata", data_sram_rdata, 32'h0);
        exp_q.delete();
        last_rdata = 0;
        data_sram_en = 0;
        cfg_r = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_req(0, 32'h1C00_0100, 32'h0, 4'h0, sc);
        check("post_rst_read_stall", sc, 3);

        // randomized traffic with random slave delays
        cfg_ar = -1; cfg_r = -1; cfg_aw = -1; cfg_w = -1; cfg_b = -1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 1) == 1)
                do_req(1, rnd_addr(), $urandom, 4'($urandom_range(1, 15)), sc);
            else
                do_req(0, rnd_addr(), 32'h0, 4'h0, sc);
        end
        check("queue_drained", exp_q.size(), 0);

`ifdef DATA_BRIDGE_ERR_EN
        check("no_err_after_okay", bus_err, 1'b0);
        cfg_bresp = 2'b10;
        do_req(1, 32'h1C00_0010, 32'hCAFEF00D, 4'hF, sc);
        check("err_set_on_bresp", bus_err, 1'b1);
        cfg_bresp = 2'b00;
        do_req(0, 32'h1C00_0010, 32'h0, 4'h0, sc);
        do_req(1, 32'h1C00_0014, 32'h01020304, 4'h1, sc);
        check("err_sticky", bus_err, 1'b1);
        reset = 1'b1;
        #1;
        check("err_cleared_by_reset", bus_err, 1'b0);
        last_rdata = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        cfg_rresp = 2'b11;
        do_req(0, 32'h1C00_0010, 32'h0, 4'h0, sc);
        check("err_set_on_rresp", bus_err, 1'b1);
        cfg_rresp = 2'b00;
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
